// File: rtl/param_add_accumulator_if.sv
// Purpose : operand-in / result-out handshake bundle for param_add_accumulator.
// Latency : n/a (wiring only).
// Backpressure: in_ready throttles the operand source; out_ready throttles the result.
//
// Ports
//   in_valid/in_ready/in_sum/in_cout      operand stream {cout, sum}
//   out_valid/out_ready/out_total/out_ovf result stream
interface param_add_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic             out_ovf;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_total, out_ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_total, out_ovf
  );
endinterface

// File: rtl/param_add_accumulator.sv
// Purpose : sums COUNT {cout,sum} operands into an ACC_W-bit total with a sticky overflow flag.
// Latency : out_valid rises the cycle after the COUNT-th accepted operand.
// Backpressure: result held in HOLD until out_ready; no operands accepted while holding or on clear.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous abort; drops any partial batch or held result
//   bus         param_add_accumulator_if.slave (operand in, result out)
//
// Parameters: WIDTH (sum width), COUNT (1..255 operands per batch), ACC_W (>= WIDTH+1).
module param_add_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  param_add_accumulator_if.slave  bus
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;

  logic [ACC_W-1:0]   value;
  logic [ACC_W:0]     sum_ext;
  logic               accept;

  assign value   = ACC_W'({bus.in_cout, bus.in_sum});
  assign sum_ext = {1'b0, acc} + {1'b0, value};

  // Gating with rst_n keeps in_ready low while reset is asserted, even
  // though the state register already sits in IDLE.
  assign bus.in_ready  = rst_n && !clear && (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_total = acc;
  assign bus.out_ovf   = ovf;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;

    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = value;
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = (COUNT == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt = sum_ext[ACC_W-1:0];
          ovf_nxt = ovf | sum_ext[ACC_W];
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(COUNT)) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // clear overrides whatever the FSM decided above, including a held result.
    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_param_add_accumulator.sv
module tb_param_add_accumulator;

  logic clk;
  logic rst_n;
  logic clear;
  logic clear6;

  int checks = 0;
  int errors = 0;

  param_add_accumulator_if #(.WIDTH(4), .ACC_W(8)) ia ();
  param_add_accumulator_if #(.WIDTH(4), .ACC_W(6)) ib ();

  param_add_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (ia)
  );

  param_add_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear6),
    .bus   (ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for one cycle on the 8-bit instance.
  task automatic push(input logic [4:0] v);
    ia.in_valid = 1'b1;
    {ia.in_cout, ia.in_sum} = v;
    tick();
    ia.in_valid = 1'b0;
  endtask

  task automatic push6(input logic [4:0] v);
    ib.in_valid = 1'b1;
    {ib.in_cout, ib.in_sum} = v;
    tick();
    ib.in_valid = 1'b0;
  endtask

  task automatic take();
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
  endtask

  task automatic take6();
    ib.out_ready = 1'b1;
    tick();
    ib.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    clear6 = 1'b0;
    ia.in_valid = 1'b0; ia.in_sum = '0; ia.in_cout = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_sum = '0; ib.in_cout = 1'b0; ib.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_in_ready",  32'(ia.in_ready),  32'd0);
    chk("rst_out_total", 32'(ia.out_total), 32'd0);
    chk("rst_out_ovf",   32'(ia.out_ovf),   32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(ia.in_ready), 32'd1);

    // 1: basic batch 22+16+8+15 = 61
    push(5'b10110);
    push(5'b10000);
    push(5'b01000);
    chk("t1_not_yet_valid", 32'(ia.out_valid), 32'd0);
    push(5'b01111);
    chk("t1_out_valid", 32'(ia.out_valid), 32'd1);
    chk("t1_out_total", 32'(ia.out_total), 32'h3D);
    chk("t1_out_ovf",   32'(ia.out_ovf),   32'd0);
    take();
    chk("t1_taken", 32'(ia.out_valid), 32'd0);

    // 2: ACC_W=6, 4 x 31 = 124 -> 60 with carry out
    for (int i = 0; i < 4; i++) push6(5'b11111);
    chk("t2_out_valid", 32'(ib.out_valid), 32'd1);
    chk("t2_out_total", 32'(ib.out_total), 32'd60);
    chk("t2_out_ovf",   32'(ib.out_ovf),   32'd1);
    take6();
    push6(5'd1); push6(5'd2); push6(5'd3); push6(5'd4);
    chk("t2_clean_total", 32'(ib.out_total), 32'd10);
    chk("t2_clean_ovf",   32'(ib.out_ovf),   32'd0);
    take6();

    // 3: back-pressure, 3+3+3+3 = 12 held for 5 cycles
    for (int i = 0; i < 4; i++) push(5'd3);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid",  32'(ia.out_valid), 32'd1);
      chk("t3_hold_total",  32'(ia.out_total), 32'd12);
      chk("t3_hold_ovf",    32'(ia.out_ovf),   32'd0);
      chk("t3_hold_ready",  32'(ia.in_ready),  32'd0);
      tick();
    end
    ia.out_ready = 1'b1;
    #1;
    chk("t3_ready_while_taking", 32'(ia.in_ready), 32'd0);
    tick();
    ia.out_ready = 1'b0;
    chk("t3_taken_valid", 32'(ia.out_valid), 32'd0);
    chk("t3_idle_ready",  32'(ia.in_ready),  32'd1);

    // 4: bubbles, operand every 3rd cycle; total tracks only accepts
    for (int i = 1; i <= 4; i++) begin
      push(5'(i));
      chk("t4_running", 32'(ia.out_total), 32'(i * (i + 1) / 2));
      if (i < 4) begin
        tick();
        tick();
        chk("t4_no_advance", 32'(ia.out_total), 32'(i * (i + 1) / 2));
        chk("t4_not_valid",  32'(ia.out_valid), 32'd0);
      end
    end
    chk("t4_out_valid", 32'(ia.out_valid), 32'd1);
    chk("t4_out_total", 32'(ia.out_total), 32'd10);
    take();

    // 5: asynchronous reset after two accepts
    push(5'd9);
    push(5'd9);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(ia.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(ia.in_ready),  32'd0);
    chk("t5_rst_total", 32'(ia.out_total), 32'd0);
    chk("t5_rst_ovf",   32'(ia.out_ovf),   32'd0);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(5'd1);
    chk("t5_valid", 32'(ia.out_valid), 32'd1);
    chk("t5_total", 32'(ia.out_total), 32'd4);
    take();

    // 6: clear with operand 7 offered after three accepts
    push(5'd2); push(5'd2); push(5'd2);
    clear = 1'b1;
    ia.in_valid = 1'b1;
    {ia.in_cout, ia.in_sum} = 5'd7;
    #1;
    chk("t6_ready_in_clear", 32'(ia.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    ia.in_valid = 1'b0;
    chk("t6_total_cleared", 32'(ia.out_total), 32'd0);
    chk("t6_not_valid",     32'(ia.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) push(5'd5);
    chk("t6_partial_not_valid", 32'(ia.out_valid), 32'd0);
    push(5'd5);
    chk("t6_valid", 32'(ia.out_valid), 32'd1);
    chk("t6_total", 32'(ia.out_total), 32'd20);
    chk("t6_ovf",   32'(ia.out_ovf),   32'd0);
    take();
    chk("t6_taken", 32'(ia.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
